// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl
//   Iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO registers.
//   Multiply is radix-2 shift-add, divide is restoring; one bit per cycle,
//   WIDTH iterations plus one sign-fix cycle. MTHI/MTLO write in one edge.
//
//   clk       pipeline clock
//   rst_n     asynchronous active-low reset
//   op_valid  EX presents an md/hilo operation
//   op        000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//             101 MTHI, 110 MTLO, 111 reserved
//   flush     EX instruction squashed this cycle (blocks acceptance only)
//   d_rs      rs operand
//   d_rt      rt operand
//   busy      mul/div in flight, HI/LO not yet valid
//   done      one-cycle pulse when HI/LO are written by mul/div
//   hi, lo    architectural HI/LO registers
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an op; MTHI/MTLO complete here
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// FIX   | apply signs, write HI/LO, pulse done

module muldiv_hilo_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   input  logic [2:0]       op,
   input  logic             flush,
   input  logic [WIDTH-1:0] d_rs,
   input  logic [WIDTH-1:0] d_rt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   localparam logic [2:0] OP_NONE  = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;
   localparam logic [2:0] OP_RSVD  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_acc_hi;   // mul: product upper half, div: remainder
   logic [WIDTH-1:0] r_acc_lo;   // mul: product lower half / multiplier, div: quotient
   logic [WIDTH-1:0] r_opnd;     // mul: multiplicand, div: divisor
   logic             r_is_div;
   logic             r_neg_q;    // product / quotient must be negated
   logic             r_neg_r;    // remainder must be negated (dividend sign)
   logic             r_dz;       // divisor was zero

   logic             w_accept;
   logic             w_is_signed;
   logic             w_is_mul;
   logic             w_rs_neg;
   logic             w_rt_neg;
   logic [WIDTH-1:0] w_rs_mag;
   logic [WIDTH-1:0] w_rt_mag;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_rem_sh;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0] w_quot_fix;
   logic [WIDTH-1:0] w_rem_fix;

   assign w_accept    = (r_state == S_IDLE) && op_valid && !flush &&
                        (op != OP_NONE) && (op != OP_RSVD);
   assign w_is_signed = (op == OP_MULT) || (op == OP_DIV);
   assign w_is_mul    = (op == OP_MULT) || (op == OP_MULTU);
   assign w_rs_neg    = w_is_signed & d_rs[WIDTH-1];
   assign w_rt_neg    = w_is_signed & d_rt[WIDTH-1];
   assign w_rs_mag    = w_rs_neg ? -d_rs : d_rs;
   assign w_rt_mag    = w_rt_neg ? -d_rt : d_rt;

   // Carry out of the upper-half add lands in the MSB after the shift.
   assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);

   // The remainder stays below the divisor, so the shifted value's MSB can
   // only be set when the subtract succeeds; the low WIDTH bits suffice.
   assign w_rem_sh    = {r_acc_hi, r_acc_lo[WIDTH-1]};
   assign w_ge        = (w_rem_sh >= {1'b0, r_opnd});
   assign w_diff      = w_rem_sh[WIDTH-1:0] - r_opnd;

   assign w_prod      = {r_acc_hi, r_acc_lo};
   assign w_prod_fix  = r_neg_q ? -w_prod : w_prod;
   // Divide by zero forces an all-ones quotient; the remainder path already
   // reproduces rs because the dividend sign is restored on it.
   assign w_quot_fix  = r_dz ? '1 : (r_neg_q ? -r_acc_lo : r_acc_lo);
   assign w_rem_fix   = r_neg_r ? -r_acc_hi : r_acc_hi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_opnd   <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dz     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (op == OP_MTHI) begin
                     hi <= d_rs;
                  end else if (op == OP_MTLO) begin
                     lo <= d_rs;
                  end else begin
                     r_state  <= w_is_mul ? S_MUL : S_DIV;
                     r_is_div <= !w_is_mul;
                     r_neg_q  <= w_rs_neg ^ w_rt_neg;
                     r_neg_r  <= w_rs_neg;
                     r_dz     <= (d_rt == '0);
                     r_acc_hi <= '0;
                     r_acc_lo <= w_is_mul ? w_rt_mag : w_rs_mag;
                     r_opnd   <= w_is_mul ? w_rs_mag : w_rt_mag;
                     r_cnt    <= '0;
                     busy     <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               {r_acc_hi, r_acc_lo} <= {w_mul_sum, r_acc_lo[WIDTH-1:1]};
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == LAST_CNT) r_state <= S_FIX;
            end
            S_DIV: begin
               r_acc_hi <= w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
               r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
               r_cnt    <= r_cnt + CW'(1);
               if (r_cnt == LAST_CNT) r_state <= S_FIX;
            end
            S_FIX: begin
               if (r_is_div) begin
                  hi <= w_rem_fix;
                  lo <= w_quot_fix;
               end else begin
                  {hi, lo} <= w_prod_fix;
               end
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl
//   Directed-vector bench for muldiv_hilo_ctrl (WIDTH=32). Inputs change and
//   outputs are sampled on the falling edge; the DUT acts on the rising edge.

module tb_muldiv_hilo_ctrl;

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   logic        clk;
   logic        rst_n;
   logic        op_valid;
   logic [2:0]  op;
   logic        flush;
   logic [31:0] d_rs;
   logic [31:0] d_rt;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp;
   int n_err;
   logic [31:0] last_hi;
   logic [31:0] last_lo;

   muldiv_hilo_ctrl #(.WIDTH(32)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .op_valid (op_valid),
      .op       (op),
      .flush    (flush),
      .d_rs     (d_rs),
      .d_rt     (d_rt),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Presents one op for a single cycle; returns at the falling edge of the
   // cycle after the accept edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] rs, input logic [31:0] rt,
                        input logic fl);
      @(negedge clk);
      op_valid = 1'b1;
      op       = o;
      d_rs     = rs;
      d_rt     = rt;
      flush    = fl;
      @(negedge clk);
      op_valid = 1'b0;
      op       = 3'b000;
      flush    = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [2:0] o,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic flush_mid);
      int n;
      int nb;
      issue(o, rs, rt, 1'b0);
      n  = 1;
      nb = busy ? 1 : 0;
      chk({tag, "_busy_start"}, {63'd0, busy}, 64'd1);
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
         if (busy) nb++;
         if (flush_mid && n == 3) flush = 1'b1;
         if (flush_mid && n == 8) flush = 1'b0;
         if (n == 5) chk({tag, "_hold"}, {hi, lo}, {last_hi, last_lo});
      end
      flush = 1'b0;
      chk({tag, "_done"}, {63'd0, done}, 64'd1);
      chk({tag, "_latency"}, 64'(n), 64'd34);
      chk({tag, "_busy_cycles"}, 64'(nb), 64'd33);
      chk({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
      last_hi = exp_hi;
      last_lo = exp_lo;
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      op_valid = 1'b0;
      op       = 3'b000;
      flush    = 1'b0;
      d_rs     = '0;
      d_rt     = '0;
      last_hi  = '0;
      last_lo  = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);

      run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      @(negedge clk);
      chk("done_pulse", {63'd0, done}, 64'd0);
      run_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run_op("mult_min_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
      run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      run_op("div_5_by0", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
      run_op("div_neg5_by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
      run_op("divu_big_by0", OP_DIVU, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);

      // MTHI then MTLO on consecutive cycles
      @(negedge clk);
      op_valid = 1'b1;
      op       = OP_MTHI;
      d_rs     = 32'h1234;
      @(negedge clk);
      chk("mthi_hi", {32'd0, hi}, 64'h1234);
      chk("mthi_busy", {62'd0, busy, done}, 64'd0);
      op   = OP_MTLO;
      d_rs = 32'hABCD;
      @(negedge clk);
      op_valid = 1'b0;
      op       = 3'b000;
      chk("mtlo_hilo", {hi, lo}, {32'h1234, 32'hABCD});
      chk("mtlo_busy", {62'd0, busy, done}, 64'd0);
      last_hi = 32'h1234;
      last_lo = 32'hABCD;

      // Reserved op must be ignored
      issue(3'b111, 32'h5555, 32'h6666, 1'b0);
      chk("rsvd_ignored", {30'd0, busy, done, hi, lo}, {32'h1234, 32'hABCD});

      // Flushed MULT 2*3 must not be accepted
      issue(OP_MULT, 32'd2, 32'd3, 1'b1);
      chk("flush_block_busy", {63'd0, busy}, 64'd0);
      repeat (3) @(negedge clk);
      chk("flush_block_hilo", {30'd0, busy, done, hi, lo}, {32'h1234, 32'hABCD});

      // Flush while busy has no effect
      run_op("mult_flush_mid", OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1);

      // Async reset in the middle of a divide
      issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
      repeat (9) @(negedge clk);
      chk("pre_reset_busy", {63'd0, busy}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset", {30'd0, busy, done, hi, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      last_hi = '0;
      last_lo = '0;
      run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
